// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped interrupt timer: FSM encoding,
// register offsets, CTRL field positions and mode values.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] PRESET_OFS = 2'd1;
    localparam logic [1:0] COUNT_OFS  = 2'd2;

    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only 2'b01 selects auto-reload; the other two codes fall back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/irq_timer.sv
// Programmable down-counter timer on the peripheral bridge. Drives one CP0
// hardware interrupt line. One-shot mode holds a level interrupt until a CTRL
// write acknowledges it; auto-reload mode emits a one-cycle pulse per period.
//
// Bus handshake: there is no valid/ready pair. A write is accepted on every
// posedge where we=1 (always ready); reads are combinational from addr with
// no side effects, so dout is valid whenever addr is stable.
module irq_timer
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    state_t             state_q,    state_d;
    logic               en_q,       en_d;
    logic [1:0]         mode_q,     mode_d;
    logic               im_q,       im_d;
    logic               irq_pend_q, irq_pend_d;
    logic [CNT_W-1:0]   preset_q,   preset_d;
    logic [CNT_W-1:0]   count_q,    count_d;

    logic               ctrl_wr;
    logic               preset_wr;

    assign ctrl_wr   = we && (addr == CTRL_OFS);
    assign preset_wr = we && (addr == PRESET_OFS);

    // Next-state: FSM and counter first, then CPU writes override so that a
    // CTRL write in the INT cycle wins over the FSM's EN clear / pend update.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        irq_pend_d = irq_pend_q;
        preset_d   = preset_q;
        count_d    = count_q;

        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else begin
                    // preset_q is the value before any same-cycle PRESET write.
                    count_d = preset_q;
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    irq_pend_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (is_reload(mode_q)) begin
                    irq_pend_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ctrl_wr) begin
            en_d       = din[EN_BIT];
            mode_d     = din[MODE_LSB +: 2];
            im_d       = din[IM_BIT];
            irq_pend_d = 1'b0;
        end

        if (preset_wr) begin
            preset_d = din[CNT_W-1:0];
        end
    end

    // State and register update; synchronous active-high reset aborts any count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            mode_q     <= MODE_ONESHOT;
            im_q       <= 1'b0;
            irq_pend_q <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            irq_pend_q <= irq_pend_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
        end
    end

    // Read mux; upper bits beyond CNT_W read as zero.
    always_comb begin
        dout = '0;
        case (addr)
            CTRL_OFS:   dout = {28'b0, im_q, mode_q, en_q};
            PRESET_OFS: dout = 32'(preset_q);
            COUNT_OFS:  dout = 32'(count_q);
            default:    dout = '0;
        endcase
    end

    // Interrupt is purely register-derived: no path from din or we.
    assign irq = irq_pend_q & im_q;

endmodule

// File: tb/tb_irq_timer.sv
// Self-checking bench for irq_timer: scenario tasks run in sequence, expected
// values are queued when stimulus is driven and popped at sample time.
module tb_irq_timer;
  import timer_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int errors;
  int checks;
  logic [31:0] exp_q[$];

  irq_timer #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; the write lands on the following posedge and the
  // task returns at the negedge after it.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] obs, exp;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(32'h0);
      peek(a[1:0], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, obs, exp);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    write_reg(COUNT_OFS, 32'h55);
    exp_q.push_back(32'h0);
    peek(COUNT_OFS, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL count_write_ignored got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] obs, exp;
    write_reg(PRESET_OFS, 32'd5);
    write_reg(CTRL_OFS, 32'h9);           // E0
    tick(1);                              // after E1 (LOAD)
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(5 - k));
    for (int k = 0; k < 6; k++) begin
      tick(1);                            // after E2..E7
      peek(COUNT_OFS, obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL oneshot_count step=%0d got=%0d exp=%0d", k, obs, exp);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_irq_early got=%b exp=0", irq);
    end
    tick(1);                              // after E8
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (irq !== 1'b1) begin
        errors++;
        $display("FAIL oneshot_irq_held cycle=%0d got=%b exp=1", k, irq);
      end
      tick(1);
    end
    exp_q.push_back(32'h8);               // EN cleared, IM kept
    peek(CTRL_OFS, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL oneshot_ctrl_en_clear got=%h exp=%h", obs, exp);
    end
    write_reg(CTRL_OFS, 32'h8);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_ack got=%b exp=0", irq);
    end
  endtask

  task automatic test_reload();
    logic [31:0] obs, exp;
    logic        exp_irq;
    write_reg(PRESET_OFS, 32'd3);
    write_reg(CTRL_OFS, 32'hB);           // E0
    for (int k = 1; k <= 30; k++) begin
      tick(1);                            // after Ek
      exp_irq = (k >= 6) && ((k - 6) % 6 == 0);
      exp_q.push_back({31'b0, exp_irq});
      exp = exp_q.pop_front();
      checks++;
      if ({31'b0, irq} !== exp) begin
        errors++;
        $display("FAIL reload_irq cycle=%0d got=%b exp=%b", k, irq, exp[0]);
      end
      if (k >= 8 && (k - 8) % 6 == 0) begin
        exp_q.push_back(32'd3);
        peek(COUNT_OFS, obs);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL reload_count cycle=%0d got=%0d exp=%0d", k, obs, exp);
        end
      end
    end
    write_reg(CTRL_OFS, 32'h0);
    tick(4);
  endtask

  task automatic test_masked();
    logic [31:0] obs, exp;
    write_reg(PRESET_OFS, 32'd4);
    write_reg(CTRL_OFS, 32'h1);           // E0, IM=0
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL masked_irq cycle=%0d got=%b exp=0", k, irq);
      end
    end
    checks++;
    if (dut.state_q !== ST_INT || dut.irq_pend_q !== 1'b1) begin
      errors++;
      $display("FAIL masked_reach_int state=%0d pend=%b exp=3/1", dut.state_q, dut.irq_pend_q);
    end
    tick(1);
    exp_q.push_back(32'h0);
    peek(CTRL_OFS, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL masked_ctrl got=%h exp=%h", obs, exp);
    end
    write_reg(CTRL_OFS, 32'h9);           // E0'
    checks++;
    if (dut.irq_pend_q !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_ack pend=%b irq=%b exp=0/0", dut.irq_pend_q, irq);
    end
    tick(6);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_rearm_early got=%b exp=0", irq);
    end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL masked_rearm_irq got=%b exp=1", irq);
    end
    write_reg(CTRL_OFS, 32'h0);
    tick(3);
  endtask

  task automatic test_freeze_reset();
    logic [31:0] obs, exp;
    write_reg(PRESET_OFS, 32'd10);
    write_reg(CTRL_OFS, 32'h1);           // E0
    tick(5);                              // after E5
    exp_q.push_back(32'd7);
    peek(COUNT_OFS, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL freeze_pre got=%0d exp=%0d", obs, exp);
    end
    write_reg(CTRL_OFS, 32'h0);           // lands at E6, COUNT becomes 6
    tick(3);
    exp_q.push_back(32'd6);
    peek(COUNT_OFS, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp || dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL freeze_hold count=%0d state=%0d exp=%0d/0", obs, dut.state_q, exp);
    end
    write_reg(CTRL_OFS, 32'h1);           // re-enable
    tick(1);                              // LOAD happens at this edge's successor
    exp_q.push_back(32'd10);
    tick(1);
    peek(COUNT_OFS, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL restart_load got=%0d exp=%0d", obs, exp);
    end
    tick(2);
    reset = 1'b1;
    tick(1);
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(32'h0);
      peek(a[1:0], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL midreset_read addr=%0d got=%h exp=%h", a, obs, exp);
      end
    end
    checks++;
    if (irq !== 1'b0 || dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset_state irq=%b state=%0d exp=0/0", irq, dut.state_q);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_preset_in_load();
    logic [31:0] obs, exp;
    write_reg(PRESET_OFS, 32'd2);
    write_reg(CTRL_OFS, 32'h1);           // E0
    tick(1);                              // after E1
    write_reg(PRESET_OFS, 32'd7);         // lands at E2 (LOAD)
    exp_q.push_back(32'd2);
    peek(COUNT_OFS, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL preset_in_load count=%0d exp=%0d", obs, exp);
    end
    exp_q.push_back(32'd7);
    peek(PRESET_OFS, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL preset_in_load_reg got=%0d exp=%0d", obs, exp);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [31:0] obs, exp;
    write_reg(PRESET_OFS, 32'd0);
    write_reg(CTRL_OFS, 32'h9);           // E0
    tick(2);                              // after E2
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL zero_preset_early got=%b exp=0", irq);
    end
    tick(1);                              // after E3
    checks++;
    if (irq !== 1'b1 || dut.state_q !== ST_INT) begin
      errors++;
      $display("FAIL zero_preset_irq irq=%b state=%0d exp=1/3", irq, dut.state_q);
    end
    write_reg(CTRL_OFS, 32'h9);           // lands at E4, in INT cycle
    exp_q.push_back(32'h9);
    peek(CTRL_OFS, obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp || irq !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wins ctrl=%h irq=%b exp=%h/0", obs, irq, exp);
    end
    tick(1);                              // after E5
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wins_quiet got=%b exp=0", irq);
    end
    tick(2);                              // after E7
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL cpu_wins_rerun got=%b exp=1", irq);
    end
    write_reg(CTRL_OFS, 32'h0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    we     = 1'b0;
    addr   = 2'd0;
    din    = 32'h0;
    test_reset();
    test_oneshot();
    test_reload();
    test_masked();
    test_freeze_reset();
    test_preset_in_load();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_timer.md
Name: irq_timer

Overview:
- Memory-mapped programmable down-counter timer on the CPU's peripheral bridge.
- Its irq output drives one HWInt line into the coprocessor-0 interrupt logic, making it the interrupt-source end of that interface.
- Supports one-shot mode (level interrupt held until acknowledged) and auto-reload mode (one-cycle interrupt pulse per period).

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers (1..32). Unused upper bits read as 0 and are ignored on write.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- addr  input  2  word select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- we  input  1  write strobe, sampled at posedge clk
- din  input  32  write data
- dout  output  32  read data, combinational from addr
- irq  output  1  interrupt request to CP0 HWInt bit

Behaviour:
- CTRL register fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload; 10 and 11 behave as 00.
  - [3] IM: interrupt mask.
  - Other bits are read-only 0.
- Read map: 0 returns {28'b0, IM, MODE, EN}; 1 returns PRESET; 2 returns COUNT; 3 returns 0. Reads have no side effects.
- Writes: CTRL and PRESET are writable. COUNT and reserved writes are ignored. A write to CTRL also clears irq_pend, which acts as the acknowledge.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pend=0. This gives irq=0 and dout=0 for every addr. Reset mid-count aborts immediately.
- irq = irq_pend & IM. It is registered-derived, with no combinational path from din or we.
- FSM, states IDLE, LOAD, CNT, INT, evaluated at each posedge:
  - IDLE: if EN=1, go to LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT. If EN=0, go to IDLE without loading.
  - CNT:
    - If EN=0, go to IDLE and COUNT freezes.
    - Else if COUNT != 0, COUNT <= COUNT-1.
    - Else (COUNT == 0), go to INT and set irq_pend <= 1.
  - INT, MODE=one-shot: EN <= 0, go to IDLE, irq_pend stays 1 until a CTRL write.
  - INT, MODE=auto-reload: irq_pend <= 0, go to LOAD. The result is a one-cycle irq pulse.
- Timing: CTRL write with EN=1 at edge E0. LOAD occurs at E1. COUNT=PRESET=P after E2. COUNT=0 after E2+P. irq_pend=1 after E3+P.
- Auto-reload period is P+3 cycles. PRESET=0 is legal: irq_pend asserts 3 cycles after enable.
- Simultaneous events:
  - A CPU CTRL write in the same cycle as the INT-state EN clear or irq_pend change: the CPU write wins. CTRL <= din and irq_pend <= 0.
  - A PRESET write during CNT affects only the next LOAD.
  - A PRESET write in the LOAD cycle: the old PRESET is loaded.
- Wrap-around: COUNT never underflows; it stops at 0 in CNT.
- Disabling and re-enabling restarts from LOAD. There is no resume of a frozen COUNT.

Decomposition:
- Shared package (timer_pkg):
  - FSM state encoding (2-bit: IDLE=0, LOAD=1, CNT=2, INT=3).
  - Register offsets (CTRL_OFS=0, PRESET_OFS=1, COUNT_OFS=2).
  - CTRL bit positions (EN_BIT=0, MODE_LSB=1, IM_BIT=3).
  - Mode constants (MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01).
- No sub-module is required. Register file, FSM and counter stay in one module.

Test Plan:
- Reset then read addr 0..3 -> all dout=0, irq=0. Write COUNT=0x55 -> read COUNT is still 0.
- PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> COUNT reads 5,4,3,2,1,0. irq rises 8 cycles after the CTRL edge and stays high. CTRL.EN reads 0. Write CTRL=0x8 -> irq drops on the next edge.
- PRESET=3, CTRL=0xB (auto-reload, IM) -> irq pulses exactly 1 cycle every 6 cycles for at least 4 periods. COUNT reloads to 3 after each pulse.
- PRESET=4, CTRL=0x1 (IM=0) -> irq never asserts but the FSM reaches INT. Then write CTRL=0x9 -> irq_pend cleared, a new count starts, and irq asserts at the expected cycle.
- PRESET=10, enable, clear EN when COUNT=6 -> COUNT freezes at 6 and FSM is IDLE. Re-enable -> COUNT reloads to 10. Assert reset mid-count -> all registers 0, irq=0.
- PRESET=0, one-shot with IM -> irq after 3 cycles. In the INT cycle, write CTRL=0x9 -> CTRL.EN stays 1 and irq stays 0 (CPU write wins).
